// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: instruction width, opcode field and opcodes.
// Also imported by the control decoder so both sides agree on the encoding.
package fetch_stage_pkg;

  localparam int INSTR_W = 8;
  localparam int OPC_W   = 2;
  localparam int OPC_MSB = INSTR_W - 1;
  localparam int OPC_LSB = INSTR_W - OPC_W;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_LI  = 2'b00;
  localparam opcode_t OP_ADD = 2'b01;
  localparam opcode_t OP_JMP = 2'b11;

  function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_imem_rf.sv
// Writable instruction memory: combinational read, synchronous write.
// Contents are intentionally not reset so a loaded program survives rst_n.
module imem_rf #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // A same-cycle write to raddr shows up only after the edge; read returns old data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, instruction memory and the IF/ID register.
// Optional FETCH_PREDECODE_JUMP_EN follows OP_JMP in the fetch stage itself.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int PC_W    = 6,
  parameter int INSTR_W = fetch_stage_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [OPC_W-1:0]   id_opcode,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    pc
);

  logic [INSTR_W-1:0] fetch_instr;
  logic [PC_W-1:0]    next_pc;
  logic               advance;

  imem_rf #(
    .AW (PC_W),
    .DW (INSTR_W)
  ) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (pc),
    .rdata (fetch_instr)
  );

  // Handshake: id_* is transferred on a cycle with id_valid && id_ready; while
  // id_valid && !id_ready every id_* output holds. An empty slot always refills.
  assign advance = !id_valid || id_ready;

`ifdef FETCH_PREDECODE_JUMP_EN
  logic [PC_W-1:0] jmp_off;
  assign jmp_off = PC_W'($signed(fetch_instr[INSTR_W-OPC_W-1:0]));

  always_comb begin
    next_pc = pc + PC_W'(1);
    if (fetch_instr[INSTR_W-1 -: OPC_W] == OP_JMP) next_pc = pc + jmp_off;
  end
`else
  always_comb begin
    next_pc = pc + PC_W'(1);
  end
`endif

  // Redirect flushes the slot even when stalled; id_instr/id_pc keep stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_target;
      id_valid <= 1'b0;
    end else if (advance) begin
      id_instr <= fetch_instr;
      id_pc    <= pc;
      id_valid <= 1'b1;
      pc       <= next_pc;
    end
  end

  assign id_opcode = id_instr[INSTR_W-1 -: OPC_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirect, wrap,
// async reset and the predecode-jump option (FETCH_PREDECODE_JUMP_EN).
module tb_fetch_stage;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 8;

  logic               clk;
  logic               rst_n;
  logic               imem_we;
  logic [PC_W-1:0]    imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_target;
  logic               id_ready;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [1:0]         id_opcode;
  logic [PC_W-1:0]    id_pc;
  logic [PC_W-1:0]    pc;

  int n_cmp;
  int n_err;

  fetch_stage #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_we         (imem_we),
    .imem_waddr      (imem_waddr),
    .imem_wdata      (imem_wdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_opcode       (id_opcode),
    .id_pc           (id_pc),
    .pc              (pc)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [PC_W-1:0] a, input logic [INSTR_W-1:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    @(negedge clk);
    imem_we    = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [INSTR_W-1:0] ins,
                        input logic [PC_W-1:0] ipc, input logic [PC_W-1:0] p);
    chk({tag, "_valid"}, 32'(id_valid), 32'(v));
    chk({tag, "_instr"}, 32'(id_instr), 32'(ins));
    chk({tag, "_opcode"}, 32'(id_opcode), 32'(ins[7:6]));
    chk({tag, "_id_pc"}, 32'(id_pc), 32'(ipc));
    chk({tag, "_pc"}, 32'(pc), 32'(p));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    imem_we = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    id_ready = 1'b0;
    step();

    // Program load while in reset
    wr(6'd0, 8'h05);
    wr(6'd1, 8'h4A);
    wr(6'd2, 8'h13);
    wr(6'd3, 8'h52);
    wr(6'd20, 8'h07);
    wr(6'd63, 8'h41);
    chk_id("reset", 1'b0, 8'h00, 6'd0, 6'd0);

    // Sequential fetch
    id_ready = 1'b1;
    rst_n = 1'b1;
    step();
    chk_id("seq0", 1'b1, 8'h05, 6'd0, 6'd1);
    step();
    chk_id("seq1", 1'b1, 8'h4A, 6'd1, 6'd2);

    // Stall three cycles on 4A
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_id("stall", 1'b1, 8'h4A, 6'd1, 6'd2);
    end
    id_ready = 1'b1;
    step();
    chk_id("seq2", 1'b1, 8'h13, 6'd2, 6'd3);
    step();
    chk_id("seq3", 1'b1, 8'h52, 6'd3, 6'd4);

    // Redirect while stalled: flush, one bubble, then target instruction
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 6'd20;
    step();
    chk_id("redir_bubble", 1'b0, 8'h52, 6'd3, 6'd20);
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    step();
    chk_id("redir_target", 1'b1, 8'h07, 6'd20, 6'd21);

    // Wrap 63 -> 0 with no bubble
    wr(6'd0, 8'h02);
    redirect_valid = 1'b1;
    redirect_target = 6'd63;
    step();
    chk("wrap_bubble_valid", 32'(id_valid), 32'd0);
    chk("wrap_bubble_pc", 32'(pc), 32'd63);
    redirect_valid = 1'b0;
    step();
    chk_id("wrap63", 1'b1, 8'h41, 6'd63, 6'd0);
    step();
    chk_id("wrap0", 1'b1, 8'h02, 6'd0, 6'd1);
    step();
    chk_id("wrap1", 1'b1, 8'h4A, 6'd1, 6'd2);

    // Async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_id("async_rst", 1'b0, 8'h00, 6'd0, 6'd0);
    step();
    wr(6'd4, 8'hFE);
    rst_n = 1'b1;
    step();
    chk_id("post_rst0", 1'b1, 8'h02, 6'd0, 6'd1);
    step();
    chk_id("post_rst1", 1'b1, 8'h4A, 6'd1, 6'd2);
    step();
    chk_id("post_rst2", 1'b1, 8'h13, 6'd2, 6'd3);
    step();
    chk_id("post_rst3", 1'b1, 8'h52, 6'd3, 6'd4);

    // JMP -2 at address 4
`ifdef FETCH_PREDECODE_JUMP_EN
    step();
    chk_id("jmp_4", 1'b1, 8'hFE, 6'd4, 6'd2);
    step();
    chk_id("jmp_2", 1'b1, 8'h13, 6'd2, 6'd3);
    step();
    chk_id("jmp_3", 1'b1, 8'h52, 6'd3, 6'd4);
    step();
    chk_id("jmp_4b", 1'b1, 8'hFE, 6'd4, 6'd2);
    step();
    chk_id("jmp_2b", 1'b1, 8'h13, 6'd2, 6'd3);
`else
    step();
    chk_id("nojmp_4", 1'b1, 8'hFE, 6'd4, 6'd5);
    step();
    chk("nojmp_5_valid", 32'(id_valid), 32'd1);
    chk("nojmp_5_id_pc", 32'(id_pc), 32'd5);
    chk("nojmp_5_pc", 32'(pc), 32'd6);
`endif

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
